idu_pipe: RTL and testbench

Registered, parametrised RV32I/RV32E/RV64I instruction-decode stage sitting between the IFU and the EXU. It accepts {pc, inst} over a valid/ready handshake and fully decodes each instruction: register indices, sign-extended immediate, control enables and an illegal-instruction flag. Results are buffered in a 2-entry skid buffer so that in_ready never depends combinationally on out_ready. A synchronous flush discards in-flight instructions on PC redirect.

---
 rtl/idu_pipe.sv | 268 ++++++++++++++++++++++++++
 tb/tb_idu_pipe.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idu_pipe.sv
// idu_pipe: registered RV32I/RV32E/RV64I decode stage with a 2-entry skid buffer.
// Optional feature macro IDU_STATS_EN adds saturating decoded/illegal counters.
module idu_pipe #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32,
    parameter int PCW   = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [PCW-1:0]  in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PCW-1:0]  out_pc,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_func3,
    output logic            out_func7b5,
    output logic [4:0]      out_rs1,
    output logic [4:0]      out_rs2,
    output logic [4:0]      out_rd,
    output logic [XLEN-1:0] out_imm,
    output logic            out_regen,
    output logic            out_pcjen,
    output logic            out_pcren,
    output logic            out_memren,
    output logic            out_memwen,
    output logic            out_illegal
`ifdef IDU_STATS_EN
    ,
    output logic [31:0]     stat_decoded,
    output logic [31:0]     stat_illegal
`endif
);

    typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_NONE} fmt_e;
    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_e;

    typedef struct packed {
        logic [PCW-1:0]  pc;
        logic [6:0]      opcode;
        logic [2:0]      func3;
        logic            func7b5;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] imm;
        logic            regen;
        logic            pcjen;
        logic            pcren;
        logic            memren;
        logic            memwen;
        logic            illegal;
    } entry_t;

    localparam logic [5:0] NREGS_L = 6'(NREGS);

    fmt_e               fmt;
    logic               en_regen, en_pcjen, en_pcren, en_memren, en_memwen;
    logic               bad_func3;
    logic               use_rs1, use_rs2, use_rd;
    logic               bad_reg;
    logic signed [31:0] imm32;
    entry_t             dec;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        fmt       = FMT_NONE;
        en_regen  = 1'b0;
        en_pcjen  = 1'b0;
        en_pcren  = 1'b0;
        en_memren = 1'b0;
        en_memwen = 1'b0;
        bad_func3 = 1'b0;
        case (in_inst[6:0])
            7'b0110111, 7'b0010111: begin
                fmt      = FMT_U;
                en_regen = 1'b1;
            end
            7'b1101111: begin
                fmt      = FMT_J;
                en_regen = 1'b1;
                en_pcjen = 1'b1;
            end
            7'b1100111: begin
                fmt       = FMT_I;
                en_regen  = 1'b1;
                en_pcjen  = 1'b1;
                en_pcren  = 1'b1;
                bad_func3 = (in_inst[14:12] != 3'b000);
            end
            7'b1100011: fmt = FMT_B;
            7'b0000011: begin
                fmt       = FMT_I;
                en_regen  = 1'b1;
                en_memren = 1'b1;
            end
            7'b0100011: begin
                fmt       = FMT_S;
                en_memwen = 1'b1;
            end
            7'b0010011: begin
                fmt      = FMT_I;
                en_regen = 1'b1;
            end
            7'b0110011: begin
                fmt      = FMT_R;
                en_regen = 1'b1;
            end
            7'b1110011: fmt = FMT_I;
            7'b0011011: begin
                if (XLEN == 64) begin
                    fmt      = FMT_I;
                    en_regen = 1'b1;
                end
            end
            7'b0111011: begin
                if (XLEN == 64) begin
                    fmt      = FMT_R;
                    en_regen = 1'b1;
                end
            end
            default: fmt = FMT_NONE;
        endcase
    end

    always_comb begin
        use_rs1 = fmt inside {FMT_R, FMT_I, FMT_S, FMT_B};
        use_rs2 = fmt inside {FMT_R, FMT_S, FMT_B};
        use_rd  = fmt inside {FMT_R, FMT_I, FMT_U, FMT_J};
        case (fmt)
            FMT_I:   imm32 = {{20{in_inst[31]}}, in_inst[31:20]};
            FMT_S:   imm32 = {{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]};
            FMT_B:   imm32 = {{19{in_inst[31]}}, in_inst[31], in_inst[7], in_inst[30:25],
                              in_inst[11:8], 1'b0};
            FMT_U:   imm32 = {in_inst[31:12], 12'b0};
            FMT_J:   imm32 = {{11{in_inst[31]}}, in_inst[31], in_inst[19:12], in_inst[20],
                              in_inst[30:21], 1'b0};
            default: imm32 = '0;
        endcase
    end

    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.opcode  = in_inst[6:0];
        dec.func3   = in_inst[14:12];
        dec.func7b5 = in_inst[30];
        dec.rs1     = use_rs1 ? in_inst[19:15] : 5'd0;
        dec.rs2     = use_rs2 ? in_inst[24:20] : 5'd0;
        dec.rd      = use_rd  ? in_inst[11:7]  : 5'd0;
        dec.imm     = XLEN'(imm32);
        bad_reg     = (use_rs1 && ({1'b0, in_inst[19:15]} >= NREGS_L))
                   || (use_rs2 && ({1'b0, in_inst[24:20]} >= NREGS_L))
                   || (use_rd  && ({1'b0, in_inst[11:7]}  >= NREGS_L));
        dec.illegal = (fmt == FMT_NONE) || (in_inst[1:0] != 2'b11) || bad_func3 || bad_reg;
        dec.regen   = en_regen  && !dec.illegal;
        dec.pcjen   = en_pcjen  && !dec.illegal;
        dec.pcren   = en_pcren  && !dec.illegal;
        dec.memren  = en_memren && !dec.illegal;
        dec.memwen  = en_memwen && !dec.illegal;
    end

    // Skid buffer: head_q always drives the outputs, tail_q only holds the second entry.
    state_e state_q, state_d;
    entry_t head_q, head_d, tail_q, tail_d;
    logic   in_ready_q, in_ready_d;
    logic   accept, emit;

    assign in_ready  = in_ready_q && !flush;
    assign out_valid = (state_q != EMPTY);
    assign accept    = in_valid && in_ready;
    assign emit      = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    head_d  = dec;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (accept && emit) begin
                    head_d = dec;
                end else if (accept) begin
                    tail_d  = dec;
                    state_d = TWO;
                end else if (emit) begin
                    state_d = EMPTY;
                end
            end
            TWO: begin
                if (emit) begin
                    head_d  = tail_q;
                    state_d = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
        in_ready_d = (state_d != TWO);
    end

    // NOTE: sequential state uses non-blocking assignments only.
    // NOTE: payload storage is reset too, because outputs must read zero out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign out_pc      = head_q.pc;
    assign out_opcode  = head_q.opcode;
    assign out_func3   = head_q.func3;
    assign out_func7b5 = head_q.func7b5;
    assign out_rs1     = head_q.rs1;
    assign out_rs2     = head_q.rs2;
    assign out_rd      = head_q.rd;
    assign out_imm     = head_q.imm;
    assign out_regen   = head_q.regen;
    assign out_pcjen   = head_q.pcjen;
    assign out_pcren   = head_q.pcren;
    assign out_memren  = head_q.memren;
    assign out_memwen  = head_q.memwen;
    assign out_illegal = head_q.illegal;

`ifdef IDU_STATS_EN
    logic [31:0] stat_decoded_q, stat_decoded_d;
    logic [31:0] stat_illegal_q, stat_illegal_d;

    // Counters survive flush; an emit in a flush cycle still completed downstream.
    always_comb begin
        stat_decoded_d = stat_decoded_q;
        stat_illegal_d = stat_illegal_q;
        if (emit && (stat_decoded_q != '1)) stat_decoded_d = stat_decoded_q + 32'd1;
        if (emit && head_q.illegal && (stat_illegal_q != '1))
            stat_illegal_d = stat_illegal_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stat_decoded_q <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_decoded_q <= stat_decoded_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_decoded = stat_decoded_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule

// File: tb/tb_idu_pipe.sv
// tb_idu_pipe: table vectors, backpressure/flush sequences and randomized traffic
// checked against a queue-based decode model; a second instance runs with NREGS=16.
module tb_idu_pipe;
    localparam int XLEN = 32;
    localparam int PCW  = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n, flush, in_valid, out_ready;
    logic [31:0]     in_inst;
    logic [PCW-1:0]  in_pc;

    logic            in_ready, out_valid;
    logic [PCW-1:0]  out_pc;
    logic [6:0]      out_opcode;
    logic [2:0]      out_func3;
    logic            out_func7b5;
    logic [4:0]      out_rs1, out_rs2, out_rd;
    logic [XLEN-1:0] out_imm;
    logic            out_regen, out_pcjen, out_pcren, out_memren, out_memwen, out_illegal;

    logic            e_in_ready, e_out_valid;
    logic [PCW-1:0]  e_pc;
    logic [6:0]      e_opcode;
    logic [2:0]      e_func3;
    logic            e_func7b5;
    logic [4:0]      e_rs1, e_rs2, e_rd;
    logic [XLEN-1:0] e_imm;
    logic            e_regen, e_pcjen, e_pcren, e_memren, e_memwen, e_illegal;
`ifdef IDU_STATS_EN
    logic [31:0]     stat_decoded, stat_illegal, e_stat_decoded, e_stat_illegal;
`endif

    idu_pipe #(.XLEN(XLEN), .NREGS(32), .PCW(PCW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_opcode(out_opcode), .out_func3(out_func3), .out_func7b5(out_func7b5),
        .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
        .out_regen(out_regen), .out_pcjen(out_pcjen), .out_pcren(out_pcren),
        .out_memren(out_memren), .out_memwen(out_memwen), .out_illegal(out_illegal)
`ifdef IDU_STATS_EN
        , .stat_decoded(stat_decoded), .stat_illegal(stat_illegal)
`endif
    );

    idu_pipe #(.XLEN(XLEN), .NREGS(16), .PCW(PCW)) dut_e (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(e_in_ready), .in_inst(in_inst), .in_pc(in_pc),
        .out_valid(e_out_valid), .out_ready(out_ready), .out_pc(e_pc),
        .out_opcode(e_opcode), .out_func3(e_func3), .out_func7b5(e_func7b5),
        .out_rs1(e_rs1), .out_rs2(e_rs2), .out_rd(e_rd), .out_imm(e_imm),
        .out_regen(e_regen), .out_pcjen(e_pcjen), .out_pcren(e_pcren),
        .out_memren(e_memren), .out_memwen(e_memwen), .out_illegal(e_illegal)
`ifdef IDU_STATS_EN
        , .stat_decoded(e_stat_decoded), .stat_illegal(e_stat_illegal)
`endif
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [6:0]  opcode;
        logic [2:0]  func3;
        logic        f7b5;
        logic [4:0]  rs1, rs2, rd;
        logic [31:0] imm;
        logic        regen, pcjen, pcren, memren, memwen, illegal;
    } exp_t;

    typedef struct {
        logic [31:0] inst, pc, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [4:0]  en;      // {regen, pcjen, pcren, memren, memwen}
        logic        ill, ill_e;
    } vec_t;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference decode written from the instruction-set rules, not the RTL structure.
    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc, input int nregs);
        exp_t e;
        byte  f;
        int   imm;
        bit   bad, u1, u2, ud;
        e = '0; f = 0; bad = 0; imm = 0;
        e.pc = pc; e.opcode = inst[6:0]; e.func3 = inst[14:12]; e.f7b5 = inst[30];
        case (inst[6:0])
            7'h37, 7'h17: begin f = "U"; e.regen = 1; end
            7'h6F: begin f = "J"; e.regen = 1; e.pcjen = 1; end
            7'h67: begin f = "I"; e.regen = 1; e.pcjen = 1; e.pcren = 1; bad = (inst[14:12] != 0); end
            7'h63: f = "B";
            7'h03: begin f = "I"; e.regen = 1; e.memren = 1; end
            7'h23: begin f = "S"; e.memwen = 1; end
            7'h13: begin f = "I"; e.regen = 1; end
            7'h33: begin f = "R"; e.regen = 1; end
            7'h73: f = "I";
            7'h1B: if (XLEN == 64) begin f = "I"; e.regen = 1; end
            7'h3B: if (XLEN == 64) begin f = "R"; e.regen = 1; end
            default: f = 0;
        endcase
        case (f)
            "I": imm = $signed(inst) >>> 20;
            "S": imm = (($signed(inst) >>> 25) <<< 5) | int'(inst[11:7]);
            "B": imm = (($signed(inst) >>> 31) <<< 12) | (int'(inst[7]) << 11)
                     | (int'(inst[30:25]) << 5) | (int'(inst[11:8]) << 1);
            "U": imm = int'({inst[31:12], 12'h000});
            "J": imm = (($signed(inst) >>> 31) <<< 20) | (int'(inst[19:12]) << 12)
                     | (int'(inst[20]) << 11) | (int'(inst[30:21]) << 1);
            default: imm = 0;
        endcase
        e.imm = imm;
        u1 = (f == "R") || (f == "I") || (f == "S") || (f == "B");
        u2 = (f == "R") || (f == "S") || (f == "B");
        ud = (f == "R") || (f == "I") || (f == "U") || (f == "J");
        if (u1) e.rs1 = inst[19:15];
        if (u2) e.rs2 = inst[24:20];
        if (ud) e.rd  = inst[11:7];
        if (u1 && int'(inst[19:15]) >= nregs) bad = 1;
        if (u2 && int'(inst[24:20]) >= nregs) bad = 1;
        if (ud && int'(inst[11:7])  >= nregs) bad = 1;
        if (f == 0 || inst[1:0] != 2'b11) bad = 1;
        if (bad) begin
            e.illegal = 1;
            e.regen = 0; e.pcjen = 0; e.pcren = 0; e.memren = 0; e.memwen = 0;
        end
        return e;
    endfunction

    function automatic exp_t pack_main();
        return '{out_pc, out_opcode, out_func3, out_func7b5, out_rs1, out_rs2, out_rd, out_imm,
                 out_regen, out_pcjen, out_pcren, out_memren, out_memwen, out_illegal};
    endfunction

    function automatic exp_t pack_e();
        return '{e_pc, e_opcode, e_func3, e_func7b5, e_rs1, e_rs2, e_rd, e_imm,
                 e_regen, e_pcjen, e_pcren, e_memren, e_memwen, e_illegal};
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 12))
            0:  r[6:0] = 7'h37;
            1:  r[6:0] = 7'h17;
            2:  r[6:0] = 7'h6F;
            3:  begin r[6:0] = 7'h67; if ($urandom_range(0, 3) != 0) r[14:12] = 3'b000; end
            4:  r[6:0] = 7'h63;
            5:  r[6:0] = 7'h03;
            6:  r[6:0] = 7'h23;
            7:  r[6:0] = 7'h13;
            8:  r[6:0] = 7'h33;
            9:  r[6:0] = 7'h73;
            10: r[6:0] = 7'h1B;
            11: r[6:0] = 7'h3B;
            default: ;
        endcase
        return r;
    endfunction

    task automatic send(input logic [31:0] inst, input logic [31:0] pc);
        in_inst = inst; in_pc = pc; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
    endtask

    vec_t  vecs[15];
    exp_t  q[$];
    exp_t  nxt;
    bit    m_ready, acc, emt;

    initial begin
        vecs[0]  = '{32'hFFF00093, 32'h1000, 32'hFFFFFFFF, 5'd1,  5'd0, 5'd0,  5'b10000, 1'b0, 1'b0};
        vecs[1]  = '{32'hFE000EE3, 32'h1004, 32'hFFFFFFFC, 5'd0,  5'd0, 5'd0,  5'b00000, 1'b0, 1'b0};
        vecs[2]  = '{32'h123450B7, 32'h1008, 32'h12345000, 5'd1,  5'd0, 5'd0,  5'b10000, 1'b0, 1'b0};
        vecs[3]  = '{32'h008000EF, 32'h100C, 32'h00000008, 5'd1,  5'd0, 5'd0,  5'b11000, 1'b0, 1'b0};
        vecs[4]  = '{32'h00008067, 32'h1010, 32'h00000000, 5'd0,  5'd1, 5'd0,  5'b11100, 1'b0, 1'b0};
        vecs[5]  = '{32'h00009067, 32'h1014, 32'h00000000, 5'd0,  5'd1, 5'd0,  5'b00000, 1'b1, 1'b1};
        vecs[6]  = '{32'hFF812283, 32'h1018, 32'hFFFFFFF8, 5'd5,  5'd2, 5'd0,  5'b10010, 1'b0, 1'b0};
        vecs[7]  = '{32'h0061A623, 32'h101C, 32'h0000000C, 5'd0,  5'd3, 5'd6,  5'b00001, 1'b0, 1'b0};
        vecs[8]  = '{32'h009403B3, 32'h1020, 32'h00000000, 5'd7,  5'd8, 5'd9,  5'b10000, 1'b0, 1'b0};
        vecs[9]  = '{32'hFFFFF517, 32'h1024, 32'hFFFFF000, 5'd10, 5'd0, 5'd0,  5'b10000, 1'b0, 1'b0};
        vecs[10] = '{32'h00000073, 32'h1028, 32'h00000000, 5'd0,  5'd0, 5'd0,  5'b00000, 1'b0, 1'b0};
        vecs[11] = '{32'h0000000B, 32'h102C, 32'h00000000, 5'd0,  5'd0, 5'd0,  5'b00000, 1'b1, 1'b1};
        vecs[12] = '{32'h01000813, 32'h1030, 32'h00000010, 5'd16, 5'd0, 5'd0,  5'b10000, 1'b0, 1'b1};
        vecs[13] = '{32'hFFF00091, 32'h1034, 32'h00000000, 5'd0,  5'd0, 5'd0,  5'b00000, 1'b1, 1'b1};
        vecs[14] = '{32'h011100B3, 32'h1038, 32'h00000000, 5'd1,  5'd2, 5'd17, 5'b10000, 1'b0, 1'b1};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_inst = '0; in_pc = '0;
        step(); step();
        check("rst_out_valid", 128'(out_valid), 128'(0));
        check("rst_in_ready",  128'(in_ready),  128'(0));
        check("rst_payload",   128'(pack_main()), 128'(0));
        rst_n = 1'b1;
        step();
        check("post_rst_in_ready", 128'(in_ready), 128'(1));
        check("post_rst_out_valid", 128'(out_valid), 128'(0));

        for (int i = 0; i < 15; i++) begin
            in_inst = vecs[i].inst; in_pc = vecs[i].pc; in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            check("vec_valid",  128'(out_valid), 128'(1));
            check("vec_pc",     128'(out_pc),    128'(vecs[i].pc));
            check("vec_opcode", 128'(out_opcode), 128'(vecs[i].inst[6:0]));
            check("vec_imm",    128'(out_imm),   128'(vecs[i].imm));
            check("vec_regs",   128'({out_rd, out_rs1, out_rs2}),
                  128'({vecs[i].rd, vecs[i].rs1, vecs[i].rs2}));
            check("vec_en",     128'({out_regen, out_pcjen, out_pcren, out_memren, out_memwen}),
                  128'(vecs[i].en));
            check("vec_illegal",   128'(out_illegal), 128'(vecs[i].ill));
            check("vec_illegal_e", 128'(e_illegal),   128'(vecs[i].ill_e));
            check("vec_regen_e",   128'(e_regen),     128'(vecs[i].en[4] && !vecs[i].ill_e));
            check("vec_model",     128'(pack_main()), 128'(model(vecs[i].inst, vecs[i].pc, 32)));
            check("vec_model_e",   128'(pack_e()),    128'(model(vecs[i].inst, vecs[i].pc, 16)));
            step();
            check("vec_drain", 128'({out_valid, e_out_valid}), 128'(0));
        end

        // Backpressure: two accepted, third held off, then drained in order.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'hFFF00093; in_pc = 32'h2000;
        step();
        check("bp_ready1", 128'(in_ready), 128'(1));
        in_inst = 32'h123450B7; in_pc = 32'h2004;
        step();
        check("bp_ready2", 128'({in_ready, e_in_ready}), 128'(0));
        check("bp_head", 128'(out_pc), 128'(32'h2000));
        in_inst = 32'h008000EF; in_pc = 32'h2008;
        step();
        check("bp_ready3", 128'(in_ready), 128'(0));
        check("bp_stable", 128'({out_valid, out_pc, out_imm}), 128'({1'b1, 32'h2000, 32'hFFFFFFFF}));
        out_ready = 1'b1;
        step();
        check("bp_second", 128'({out_valid, out_pc, out_imm}), 128'({1'b1, 32'h2004, 32'h12345000}));
        check("bp_ready4", 128'(in_ready), 128'(1));
        step();
        check("bp_third", 128'({out_valid, out_pc, out_imm}), 128'({1'b1, 32'h2008, 32'h8}));
        in_valid = 1'b0;
        step();
        check("bp_empty", 128'(out_valid), 128'(0));

        // Flush from TWO with an input offered, then from ONE where it would be accepted.
        out_ready = 1'b0; in_valid = 1'b1;
        in_inst = 32'hFFF00093; in_pc = 32'h3000; step();
        in_pc = 32'h3004; step();
        check("fl_two", 128'(in_ready), 128'(0));
        flush = 1'b1; in_pc = 32'h3008;
        #1;
        check("fl_ready_during", 128'(in_ready), 128'(0));
        step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_after_two", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
        in_valid = 1'b1; in_pc = 32'h300C; step();
        check("fl_one", 128'(out_valid), 128'(1));
        flush = 1'b1; in_pc = 32'h3010; step();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("fl_after_one", 128'({out_valid, in_ready}), 128'({1'b0, 1'b1}));
        step();
        check("fl_not_accepted", 128'(out_valid), 128'(0));

        // Randomized traffic against the queue model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            in_inst   = rand_inst();
            in_pc     = $urandom;
            #1;
            m_ready = (q.size() < 2) && !flush;
            check("rnd_in_ready", 128'(in_ready), 128'(m_ready));
            acc = in_valid && m_ready;
            emt = (q.size() > 0) && out_ready;
            nxt = model(in_inst, in_pc, 32);
            step();
            if (emt) void'(q.pop_front());
            if (acc) q.push_back(nxt);
            if (flush) q.delete();
            check("rnd_out_valid", 128'(out_valid), 128'(q.size() > 0));
            if (q.size() > 0) check("rnd_head", 128'(pack_main()), 128'(q[0]));
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step();

`ifdef IDU_STATS_EN
        rst_n = 1'b0; step();
        rst_n = 1'b1; step();
        check("st_rst", 128'({stat_decoded, stat_illegal}), 128'(0));
        send(32'hFFF00093, 32'h4000);
        send(32'h0000000B, 32'h4004);
        send(32'h123450B7, 32'h4008);
        send(32'h009403B3, 32'h400C);
        send(32'h00009067, 32'h4010);
        send(32'h0061A623, 32'h4014);
        send(32'h00000073, 32'h4018);
        check("st_counts",   128'({stat_decoded, stat_illegal}),     128'({32'd7, 32'd2}));
        check("st_counts_e", 128'({e_stat_decoded, e_stat_illegal}), 128'({32'd7, 32'd2}));
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0000000B; in_pc = 32'h401C;
        step();
        in_valid = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        check("st_flush", 128'({stat_decoded, stat_illegal, out_valid}), 128'({32'd7, 32'd2, 1'b0}));
        rst_n = 1'b0; step();
        check("st_clear", 128'({stat_decoded, stat_illegal}), 128'(0));
        rst_n = 1'b1; out_ready = 1'b1; step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
